// File: rtl/pwm_generator_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_generator_multi_if
// Description : Control and status bundle for pwm_generator_multi.
//               master = controller side that drives enable and the buttons.
//               slave  = PWM generator.
// Revision    : 1.0  initial release
// ============================================================================
interface pwm_generator_multi_if #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 5
);
    logic                          enable;
    logic [CHANNELS-1:0]           inc_btn;
    logic [CHANNELS-1:0]           dec_btn;
    logic [CHANNELS-1:0]           pwm_out;
    logic                          period_tick;
    logic [CHANNELS*(CNT_W+1)-1:0] duty;

    modport master (
        output enable, inc_btn, dec_btn,
        input  pwm_out, period_tick, duty
    );

    modport slave (
        input  enable, inc_btn, dec_btn,
        output pwm_out, period_tick, duty
    );
endinterface
`default_nettype wire

// File: rtl/pwm_generator_multi.sv
`default_nettype none
// ============================================================================
// Module      : pwm_generator_multi
// Description : Multi-channel PWM generator sharing one period counter.
//               Per-channel duty is stepped by debounced inc/dec buttons into
//               a pending register and copied to the active register only at
//               a period boundary (or continuously while disabled), so the
//               outputs never glitch mid-period.
//               Optional macro PWM_CENTER_ALIGNED_EN selects an up/down
//               counter (centre-aligned pulses, period = 2*PERIOD cycles).
// Revision    : 1.0  initial release
// ============================================================================
module pwm_generator_multi #(
    parameter int CHANNELS     = 2,
    parameter int CNT_W        = 5,
    parameter int PERIOD       = 32,
    parameter int DUTY_INIT    = 16,
    parameter int STEP         = 1,
    parameter int DEBOUNCE_DIV = 2
) (
    input  wire logic            clk,
    input  wire logic            reset,
    pwm_generator_multi_if.slave bus
);
    // Duty registers carry one extra bit so that 100% (== PERIOD) fits.
    localparam int                 c_DW        = CNT_W + 1;
    localparam int                 c_DIV_W     = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(DEBOUNCE_DIV - 1);
    localparam logic [CNT_W-1:0]   c_CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [c_DW-1:0]    c_DUTY_MAX  = c_DW'(PERIOD);
    localparam logic [c_DW-1:0]    c_DUTY_INIT = c_DW'(DUTY_INIT);
    localparam logic [c_DW-1:0]    c_STEP_N    = c_DW'(STEP);
    localparam logic [c_DW:0]      c_STEP_W    = (c_DW + 1)'(STEP);

    logic [c_DIV_W-1:0]       r_div;
    logic                     w_sample_en;
    logic [CHANNELS-1:0]      r_inc_s1;
    logic [CHANNELS-1:0]      r_inc_s2;
    logic [CHANNELS-1:0]      r_dec_s1;
    logic [CHANNELS-1:0]      r_dec_s2;
    logic [CHANNELS-1:0]      w_inc_press;
    logic [CHANNELS-1:0]      w_dec_press;
    logic [CNT_W-1:0]         r_cnt;
    logic                     w_tick;
    logic [c_DW-1:0]          r_pending [CHANNELS];
    logic [c_DW-1:0]          r_active  [CHANNELS];
    logic [c_DW-1:0]          w_inc_val [CHANNELS];
    logic [c_DW-1:0]          w_dec_val [CHANNELS];
    logic [CHANNELS-1:0]      r_pwm;
    logic [CHANNELS*c_DW-1:0] w_duty;

    // Free-running debounce divider; the sample strobe marks its last count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
        end else if (r_div == c_DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_sample_en = (r_div == c_DIV_LAST);

    // Two-stage button samplers, advanced only on the sample strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inc_s1 <= '0;
            r_inc_s2 <= '0;
            r_dec_s1 <= '0;
            r_dec_s2 <= '0;
        end else if (w_sample_en) begin
            r_inc_s1 <= bus.inc_btn;
            r_inc_s2 <= r_inc_s1;
            r_dec_s1 <= bus.dec_btn;
            r_dec_s2 <= r_dec_s1;
        end
    end

    // Rising edge seen by the samplers, one clock wide.
    assign w_inc_press = r_inc_s1 & ~r_inc_s2 & {CHANNELS{w_sample_en}};
    assign w_dec_press = r_dec_s1 & ~r_dec_s2 & {CHANNELS{w_sample_en}};

`ifdef PWM_CENTER_ALIGNED_EN
    localparam logic [0:0] c_DIR_UP   = 1'b0;
    localparam logic [0:0] c_DIR_DOWN = 1'b1;

    logic [0:0] r_dir;

    // Up/down counter; each endpoint is held one extra cycle while turning.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_dir <= c_DIR_UP;
        end else if (!bus.enable) begin
            r_cnt <= '0;
            r_dir <= c_DIR_UP;
        end else if (r_dir == c_DIR_UP) begin
            if (r_cnt == c_CNT_LAST) begin
                r_dir <= c_DIR_DOWN;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            if (r_cnt == '0) begin
                r_dir <= c_DIR_UP;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Period ends on the final down-count cycle at zero.
    assign w_tick = bus.enable && (r_dir == c_DIR_DOWN) && (r_cnt == '0);
`else
    // Edge-aligned up-counter wrapping PERIOD-1 -> 0, cleared while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!bus.enable || (r_cnt == c_CNT_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_tick = bus.enable && (r_cnt == c_CNT_LAST);
`endif

    // Saturating next-duty candidates per channel.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [c_DW:0] w_sum;
        assign w_sum         = {1'b0, r_pending[gi]} + c_STEP_W;
        assign w_inc_val[gi] = (w_sum > {1'b0, c_DUTY_MAX}) ? c_DUTY_MAX : w_sum[c_DW-1:0];
        assign w_dec_val[gi] = (r_pending[gi] < c_STEP_N) ? '0 : (r_pending[gi] - c_STEP_N);
    end

    // Pending duty: a lone inc or dec press steps it; both together cancel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_pending[i] <= c_DUTY_INIT;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_inc_press[i] && !w_dec_press[i]) begin
                    r_pending[i] <= w_inc_val[i];
                end else if (w_dec_press[i] && !w_inc_press[i]) begin
                    r_pending[i] <= w_dec_val[i];
                end
            end
        end
    end

    // Shadow copy at the period boundary, or every cycle while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_active[i] <= c_DUTY_INIT;
            end
        end else if (!bus.enable || w_tick) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_active[i] <= r_pending[i];
            end
        end
    end

    // Registered compare; the output trails the counter by one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_pwm[i] <= bus.enable && ({1'b0, r_cnt} < r_active[i]);
            end
        end
    end

    // Pack active duties, channel 0 in the least significant field.
    always_comb begin
        w_duty = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_duty[i*c_DW +: c_DW] = r_active[i];
        end
    end

    assign bus.pwm_out     = r_pwm;
    assign bus.period_tick = w_tick;
    assign bus.duty        = w_duty;
endmodule
`default_nettype wire

// File: tb/tb_pwm_generator_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_generator_multi
// Description : Scoreboard bench for pwm_generator_multi. The stimulus pushes
//               the expected per-period result (high time and duty of both
//               channels) when a period starts; a negedge monitor measures
//               each complete period and pops/compares at its end.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pwm_generator_multi;
    localparam int c_CHANNELS = 2;
    localparam int c_CNT_W    = 5;
    localparam int c_PERIOD   = 32;
    localparam int c_INIT     = 16;
`ifdef PWM_CENTER_ALIGNED_EN
    localparam int c_MUL      = 2;
`else
    localparam int c_MUL      = 1;
`endif
    localparam int c_SPACING  = c_PERIOD * c_MUL;
    localparam int c_BUDGET   = 4 * c_SPACING + 16;

    typedef struct {
        int high0;
        int high1;
        int duty0;
        int duty1;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pwm_generator_multi_if #(.CHANNELS(c_CHANNELS), .CNT_W(c_CNT_W)) bus_if ();

    pwm_generator_multi #(
        .CHANNELS    (c_CHANNELS),
        .CNT_W       (c_CNT_W),
        .PERIOD      (c_PERIOD),
        .DUTY_INIT   (c_INIT),
        .STEP        (1),
        .DEBOUNCE_DIV(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int duty_of(input int ch);
        logic [c_CNT_W:0] v;
        v = bus_if.duty[ch*(c_CNT_W+1) +: (c_CNT_W+1)];
        return int'(v);
    endfunction

    // Monitor: accumulate high cycles per period, compare at period end.
    int acc0 = 0;
    int acc1 = 0;
    int gap  = 0;
    int cap0 = 0;
    int cap1 = 0;
    bit prev_tick = 1'b0;
    bit have_prev = 1'b0;

    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            acc0 = 0; acc1 = 0; gap = 0;
            prev_tick = 1'b0; have_prev = 1'b0;
        end else begin
            acc0 += int'(bus_if.pwm_out[0]);
            acc1 += int'(bus_if.pwm_out[1]);
            if (prev_tick) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: period ended with no expectation, high0=%0d high1=%0d",
                             acc0, acc1);
                end else begin
                    e = sb.pop_front();
                    check("period_high0", acc0, e.high0);
                    check("period_high1", acc1, e.high1);
                    check("period_duty0", cap0, e.duty0);
                    check("period_duty1", cap1, e.duty1);
                end
                acc0 = 0; acc1 = 0;
            end
            if (!bus_if.enable) begin
                acc0 = 0; acc1 = 0; gap = 0;
                have_prev = 1'b0;
            end else begin
                gap++;
                if (bus_if.period_tick) begin
                    if (have_prev) check("tick_spacing", gap, c_SPACING);
                    have_prev = 1'b1;
                    gap  = 0;
                    cap0 = duty_of(0);
                    cap1 = duty_of(1);
                end
            end
            prev_tick = bus_if.period_tick;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input int d0, input int d1);
        exp_t e;
        e.high0 = d0 * c_MUL;
        e.high1 = d1 * c_MUL;
        e.duty0 = d0;
        e.duty1 = d1;
        sb.push_back(e);
    endtask

    // Wait for the last cycle of a period, return just inside the next one.
    task automatic wait_tick();
        bit found = 1'b0;
        for (int i = 0; i < c_BUDGET && !found; i++) begin
            @(negedge clk);
            if (bus_if.period_tick) found = 1'b1;
        end
        check("tick_seen", int'(found), 1);
        @(posedge clk);
        #2;
    endtask

    task automatic press(input logic [1:0] inc, input logic [1:0] dec);
        bus_if.inc_btn = inc;
        bus_if.dec_btn = dec;
        step(6);
        bus_if.inc_btn = '0;
        bus_if.dec_btn = '0;
        step(6);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        bus_if.enable  = 1'b0;
        bus_if.inc_btn = '0;
        bus_if.dec_btn = '0;
        step(3);
        @(negedge clk);
        check("rst_pwm", int'(bus_if.pwm_out), 0);
        check("rst_tick", int'(bus_if.period_tick), 0);
        check("rst_duty0", duty_of(0), 16);
        check("rst_duty1", duty_of(1), 16);
        step(1);
        reset = 1'b0;
        step(2);

        // Free-running at the reset duty.
        push(16, 16);
        bus_if.enable = 1'b1;
        wait_tick();
        push(16, 16);
        wait_tick();

        // Simultaneous inc and dec on ch0 cancel.
        push(16, 16);
        step(2);
        press(2'b01, 2'b01);
        @(negedge clk);
        check("same_cycle_duty0", duty_of(0), 16);
        wait_tick();

        // A mid-period press is held until the boundary.
        push(16, 16);
        step(2);
        press(2'b01, 2'b00);
        @(negedge clk);
        check("shadow_hold_duty0", duty_of(0), 16);
        wait_tick();
        push(17, 16);
        @(negedge clk);
        check("shadow_apply_duty0", duty_of(0), 17);
        wait_tick();

        // Drop enable mid-period; outputs go low on the next clock.
        step(8);
        @(negedge clk);
        check("pre_disable_pwm0", int'(bus_if.pwm_out[0]), 1);
        step(1);
        bus_if.enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("disable_pwm", int'(bus_if.pwm_out), 0);
        step(1);
        press(2'b01, 2'b00);
        @(negedge clk);
        check("disabled_press_duty0", duty_of(0), 18);
        check("disabled_pwm", int'(bus_if.pwm_out), 0);

        // Saturation at PERIOD on ch1.
        step(1);
        repeat (20) press(2'b10, 2'b00);
        @(negedge clk);
        check("sat_high_duty1", duty_of(1), 32);
        step(1);
        push(18, 32);
        bus_if.enable = 1'b1;
        wait_tick();
        bus_if.enable = 1'b0;

        // Saturation at zero on ch1, then ch0 up to 25.
        repeat (40) press(2'b00, 2'b10);
        @(negedge clk);
        check("sat_low_duty1", duty_of(1), 0);
        step(1);
        repeat (7) press(2'b01, 2'b00);
        @(negedge clk);
        check("duty0_25", duty_of(0), 25);
        step(1);
        push(25, 0);
        bus_if.enable = 1'b1;
        wait_tick();

        // Asynchronous reset mid-period with a press in flight.
        step(8);
        @(negedge clk);
        check("pre_reset_pwm0", int'(bus_if.pwm_out[0]), 1);
        step(1);
        bus_if.inc_btn = 2'b10;
        step(3);
        reset = 1'b1;
        #1;
        check("async_rst_pwm", int'(bus_if.pwm_out), 0);
        check("async_rst_duty0", duty_of(0), 16);
        bus_if.inc_btn = '0;
        bus_if.enable  = 1'b0;
        step(3);
        reset = 1'b0;
        step(8);
        @(negedge clk);
        check("post_rst_duty0", duty_of(0), 16);
        check("press_lost_duty1", duty_of(1), 16);

        // One more full period back at the reset duty.
        step(1);
        push(16, 16);
        bus_if.enable = 1'b1;
        wait_tick();
        step(2);
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
